// File: rtl/fifo_readout_control.sv
// -----------------------------------------------------------------------------
// fifo_readout_control
//
// Read-side framer for the event data FIFO. The block drains a first-word-
// fall-through FIFO and sends its contents to the host link as packets on a
// ready/valid stream:
//
//   header  : {HDR_TAG, seq[15:0]}   (zero-extended to DATA_WIDTH)
//   payload : len FIFO words, in FIFO order
//   trailer : {TRL_TAG, len[15:0]}   (zero-extended, TX_TLAST=1)
//
// A full packet of PKT_WORDS is started whenever the FIFO holds at least that
// many words. When the run controller is back in IDLE, whatever is left in the
// FIFO is flushed as a short packet. Each packet is separated from the next by
// at least one idle cycle.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   RUN_STATUS      run state: 000 INIT, 001 IDLE, 010 STARTUP, 011 WAIT, 100 BUSY
//   FIFO_DOUT       FWFT FIFO head word, valid while FIFO_EMPTY=0
//   FIFO_EMPTY      FIFO empty flag
//   FIFO_RD_COUNT   FIFO read data count
//   FIFO_RD_EN      pop strobe (combinational, only during payload transfers)
//   TX_TDATA        stream data
//   TX_TVALID       stream valid (never depends on TX_TREADY)
//   TX_TLAST        last word of a packet (the trailer)
//   TX_TREADY       stream ready
//   PKT_SEQ         sequence number of the next packet to be sent
//   BUSY            high whenever a packet is in progress
// -----------------------------------------------------------------------------
module fifo_readout_control #(
    parameter int          DATA_WIDTH = 32,
    parameter int          PKT_WORDS  = 256,
    parameter int          CNT_WIDTH  = 12,
    parameter logic [15:0] HDR_TAG    = 16'hEB90,
    parameter logic [15:0] TRL_TAG    = 16'h5A5A
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [2:0]            RUN_STATUS,
    input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
    input  logic                  FIFO_EMPTY,
    input  logic [CNT_WIDTH-1:0]  FIFO_RD_COUNT,
    output logic                  FIFO_RD_EN,
    output logic [DATA_WIDTH-1:0] TX_TDATA,
    output logic                  TX_TVALID,
    output logic                  TX_TLAST,
    input  logic                  TX_TREADY,
    output logic [15:0]           PKT_SEQ,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_TRL  = 2'd3
    } state_t;

    localparam logic [2:0] RS_IDLE    = 3'b001;
    localparam logic [2:0] RS_STARTUP = 3'b010;

    // The count comparison is done at a width that holds both the FIFO count
    // and any legal PKT_WORDS (up to 65535), so neither side gets truncated.
    localparam int                CMP_W   = (CNT_WIDTH > 17) ? CNT_WIDTH : 17;
    localparam logic [CMP_W-1:0]  PKT_EXT = CMP_W'(PKT_WORDS);
    localparam logic [15:0]       PKT_LEN = 16'(PKT_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] seq_q;
    logic [15:0] seq_nxt;
    logic [15:0] len_q;
    logic [15:0] len_nxt;
    logic [15:0] idx_q;
    logic [15:0] idx_nxt;

    logic        full_ok;
    logic        flush_ok;
    logic        pay_vld;
    logic        pay_pop;

    // Packet length from the FIFO count, clamped to a full packet so a wide
    // count can never produce an over-long packet.
    function automatic logic [15:0] sat_len(input logic [CNT_WIDTH-1:0] cnt);
        if (CMP_W'(cnt) >= PKT_EXT) begin
            return PKT_LEN;
        end
        return 16'(cnt);
    endfunction

    assign full_ok  = (CMP_W'(FIFO_RD_COUNT) >= PKT_EXT);
    assign flush_ok = (RUN_STATUS == RS_IDLE) && !FIFO_EMPTY && !full_ok;

    // Payload words are only offered while the FIFO has a word at its head;
    // a pop happens exactly when such a word is accepted downstream.
    assign pay_vld  = !FIFO_EMPTY;
    assign pay_pop  = pay_vld && TX_TREADY;

    // ---- state / counter registers ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            seq_q <= 16'd0;
            len_q <= 16'd0;
            idx_q <= 16'd0;
        end else begin
            state <= state_nxt;
            seq_q <= seq_nxt;
            len_q <= len_nxt;
            idx_q <= idx_nxt;
        end
    end

    // ---- next-state and output decode ----
    always_comb begin
        state_nxt  = state;
        seq_nxt    = seq_q;
        len_nxt    = len_q;
        idx_nxt    = idx_q;
        TX_TVALID  = 1'b0;
        TX_TLAST   = 1'b0;
        TX_TDATA   = '0;
        FIFO_RD_EN = 1'b0;

        case (state)
            S_IDLE: begin
                // A new run restarts the packet numbering.
                if (RUN_STATUS == RS_STARTUP) begin
                    seq_nxt = 16'd0;
                end
                // Full packets take priority over a flush.
                if (full_ok) begin
                    len_nxt   = PKT_LEN;
                    state_nxt = S_HDR;
                end else if (flush_ok) begin
                    len_nxt   = sat_len(FIFO_RD_COUNT);
                    state_nxt = S_HDR;
                end
            end

            S_HDR: begin
                TX_TVALID = 1'b1;
                TX_TDATA  = DATA_WIDTH'({HDR_TAG, seq_q});
                if (TX_TREADY) begin
                    idx_nxt = 16'd0;
                    // A FWFT count that lags the empty flag can yield a zero
                    // length; such a packet carries no payload at all.
                    state_nxt = (len_q == 16'd0) ? S_TRL : S_PAY;
                end
            end

            S_PAY: begin
                TX_TVALID  = pay_vld;
                TX_TDATA   = FIFO_DOUT;
                FIFO_RD_EN = pay_pop;
                if (pay_pop) begin
                    idx_nxt = idx_q + 16'd1;
                    if (idx_q == len_q - 16'd1) begin
                        state_nxt = S_TRL;
                    end
                end
            end

            S_TRL: begin
                TX_TVALID = 1'b1;
                TX_TLAST  = 1'b1;
                TX_TDATA  = DATA_WIDTH'({TRL_TAG, len_q});
                if (TX_TREADY) begin
                    seq_nxt   = seq_q + 16'd1;
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign PKT_SEQ = seq_q;
    assign BUSY    = (state != S_IDLE);

endmodule

// File: doc/fifo_readout_control.md
Name: fifo_readout_control

Overview:
- Read-side companion of the run/state controller.
- Drains the event data FIFO written under FIFO_WR_EN and frames the data into packets on a ready/valid stream toward the host link (Ethernet/PCIe TX).
- Each packet is a header word, then the payload words, then a trailer word.
- Full packets are sent while running; when the run returns to IDLE, the FIFO is flushed as a short packet.

Parameters:
- DATA_WIDTH, 32, FIFO and stream word width; must be ≥ 32.
- PKT_WORDS, 256, payload words per full packet; range 1 to 65535.
- CNT_WIDTH, 12, width of the FIFO read data count.
- HDR_TAG, 16'hEB90, upper 16 bits of the header word.
- TRL_TAG, 16'h5A5A, upper 16 bits of the trailer word.

Ports:
- CLK, in, 1, system clock.
- RST, in, 1, asynchronous active-high reset.
- RUN_STATUS, in, 3, run state from the state controller: 000 INIT, 001 IDLE, 010 STARTUP, 011 WAIT, 100 BUSY.
- FIFO_DOUT, in, DATA_WIDTH, first-word-fall-through FIFO data. Valid whenever FIFO_EMPTY=0.
- FIFO_EMPTY, in, 1, FIFO empty flag.
- FIFO_RD_COUNT, in, CNT_WIDTH, FIFO read data count.
- FIFO_RD_EN, out, 1, pops one word; combinational.
- TX_TDATA, out, DATA_WIDTH, stream data.
- TX_TVALID, out, 1, stream valid.
- TX_TLAST, out, 1, marks the last word of a packet (the trailer).
- TX_TREADY, in, 1, stream ready.
- PKT_SEQ, out, 16, sequence number of the next packet to be sent.
- BUSY, out, 1, high in any state other than S_IDLE.

Behaviour:
- Reset: RST is asynchronous and active-high.
  - State goes to S_IDLE; sequence counter, length register and word index go to 0.
  - All outputs are 0 while RST=1: TX_TVALID, TX_TLAST, TX_TDATA, FIFO_RD_EN, BUSY, PKT_SEQ.
  - Reset mid-packet aborts the packet immediately, with no trailer. The unsent FIFO words remain in the FIFO.
- Handshake: a word transfers on a CLK edge with TX_TVALID=1 and TX_TREADY=1.
  - Once TX_TVALID is asserted, TX_TDATA and TX_TLAST stay stable until the transfer.
  - TX_TVALID never depends on TX_TREADY.
- Definitions:
  - full_ok = FIFO_RD_COUNT ≥ PKT_WORDS.
  - flush_ok = (RUN_STATUS == 001) and FIFO_EMPTY=0 and not full_ok.
- State S_IDLE:
  - Outputs: TX_TVALID=0, BUSY=0.
  - If RUN_STATUS == 010 (STARTUP), the sequence counter clears to 0. A new run restarts the numbering.
  - If full_ok: len ← PKT_WORDS; go to S_HDR on the next edge.
  - Else if flush_ok: len ← FIFO_RD_COUNT; go to S_HDR on the next edge.
  - full_ok has priority over flush_ok.
  - Decision latency is 1 cycle: the condition is sampled on edge n, and TX_TVALID goes high after edge n.
- State S_HDR:
  - Outputs: TX_TVALID=1, TX_TDATA = {zero-extend, HDR_TAG, seq[15:0]}, TX_TLAST=0.
  - On transfer: index ← 0; go to S_PAY.
- State S_PAY:
  - Outputs: TX_TDATA = FIFO_DOUT, TX_TVALID = ~FIFO_EMPTY, TX_TLAST=0.
  - FIFO_RD_EN = TX_TVALID & TX_TREADY.
  - On each transfer, index increments. When the transfer is word len−1, go to S_TRL.
  - If the FIFO is momentarily empty, TX_TVALID drops and the packet stalls. No word is lost or duplicated.
- State S_TRL:
  - Outputs: TX_TVALID=1, TX_TDATA = {zero-extend, TRL_TAG, len[15:0]}, TX_TLAST=1.
  - On transfer: seq ← seq+1 (16-bit, wraps FFFF→0000); go to S_IDLE.
  - S_IDLE re-evaluates on the following edge, so packets are separated by at least one idle cycle.
- FIFO_RD_EN is 0 in every state except S_PAY.
- RUN_STATUS changes during a packet are ignored; the packet always completes with its latched len.
- While RUN_STATUS is WAIT or BUSY, a partial FIFO (count < PKT_WORDS) is not sent.
- Flushing repeats each time S_IDLE is entered, until the FIFO is empty.
- The length field is len truncated to 16 bits. If FIFO_RD_COUNT is wider than needed, len saturates at PKT_WORDS.
- Implemented states S_IDLE, S_HDR, S_PAY, S_TRL (2-bit encoding). Undefined encodings are unreachable; the default branch goes to S_IDLE.

Test Plan:
- PKT_WORDS=4, RUN_STATUS=011, FIFO preloaded with words 1..8, TX_TREADY=1 → two packets:
  - EB90_0000, 1, 2, 3, 4, 5A5A_0004 (TLAST on the trailer);
  - then EB90_0001, 5, 6, 7, 8, 5A5A_0004.
  - Exactly 8 FIFO_RD_EN pulses; PKT_SEQ ends at 2.
- TX_TREADY toggled pseudo-randomly, 10 full packets → payload stream equals FIFO order. TDATA and TLAST are stable while VALID=1 and READY=0.
- RUN_STATUS=011 with 3 words buffered → no packet. Switch RUN_STATUS to 001 → one packet EB90_xxxx, w0, w1, w2, 5A5A_0003, and the FIFO ends empty.
- FIFO_EMPTY forced high for 5 cycles mid-payload → TX_TVALID=0 and FIFO_RD_EN=0 during the gap; the packet resumes with the correct next word.
- Preset seq to FFFF → the next header is EB90_FFFF and the following one EB90_0000. Pulse RUN_STATUS=010 while in S_IDLE → PKT_SEQ=0.
- Assert RST asynchronously mid-payload → same-cycle TX_TVALID=0 and FIFO_RD_EN=0, state returns to S_IDLE. After release, the next packet header carries seq 0000.
